// File: rtl/mx_blk_dec.sv
// mx_blk_dec: streaming MX block decoder.
// Turns one scale beat plus block_size minifloat elements into exact signed integers.
module mx_blk_dec #(
  parameter int width_exp   = 5,
  parameter int width_man   = 2,
  parameter int width_scale = 8,
  parameter int block_size  = 32,
  parameter int width_i     = 8,
  localparam int width_o    = width_man + 2**width_exp
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [width_i-1:0]     i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [width_o-1:0]     o_num,
  output logic [width_scale-1:0] o_scale,
  output logic                   o_nan,
  output logic                   o_last,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam int width_cnt = (block_size > 1) ? $clog2(block_size) : 1;
  localparam int sb        = width_exp + width_man;

  typedef enum logic {S_SCALE, S_ELEM} state_t;

  state_t                 state_q, state_d;
  logic [width_cnt-1:0]   cnt_q, cnt_d;
  logic [width_scale-1:0] scl_q, scl_d;
  logic [width_o-1:0]     num_q, num_d;
  logic [width_scale-1:0] oscl_q, oscl_d;
  logic                   nan_q, nan_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;

  logic                   in_xfer, out_xfer;
  logic                   elem_xfer, cnt_end;
  logic                   s;
  logic [width_exp-1:0]   e;
  logic [width_man-1:0]   m;
  logic [width_o-1:0]     mag;

  assign o_ready   = !valid_q || i_ready;
  assign in_xfer   = i_valid && o_ready;
  assign out_xfer  = valid_q && i_ready;
  assign elem_xfer = in_xfer && (state_q == S_ELEM);
  assign cnt_end   = cnt_q == width_cnt'(block_size - 1);

  assign s = i_data[sb];
  assign e = i_data[sb-1:width_man];
  assign m = i_data[width_man-1:0];

  assign o_num   = num_q;
  assign o_scale = oscl_q;
  assign o_nan   = nan_q;
  assign o_last  = last_q;
  assign o_valid = valid_q;

  // Exact magnitude: subnormals are m, normals shift the implicit-one mantissa.
  always_comb begin
    mag = '0;
    if (e == '0) mag = width_o'(m);
    else mag = width_o'({1'b1, m}) << (e - width_exp'(1));
  end

  // State, counter, scale and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_SCALE;
      cnt_q   <= '0;
      scl_q   <= '0;
      num_q   <= '0;
      oscl_q  <= '0;
      nan_q   <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scl_q   <= scl_d;
      num_q   <= num_d;
      oscl_q  <= oscl_d;
      nan_q   <= nan_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Next state: scale beat, then block_size element beats.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scl_d   = scl_q;
    unique case (1'b1)
      (state_q == S_SCALE): begin
        if (in_xfer) begin
          scl_d   = i_data[width_scale-1:0];
          state_d = S_ELEM;
        end
      end
      default: begin
        if (in_xfer) begin
          if (cnt_end) begin
            cnt_d   = '0;
            state_d = S_SCALE;
          end else begin
            cnt_d = cnt_q + width_cnt'(1);
          end
        end
      end
    endcase
  end

  // Output register load: drop on consume, reload on element accept.
  always_comb begin
    valid_d = valid_q;
    num_d   = num_q;
    oscl_d  = oscl_q;
    nan_d   = nan_q;
    last_d  = last_q;
    if (out_xfer) valid_d = 1'b0;
    if (elem_xfer) begin
      valid_d = 1'b1;
      num_d   = s ? -mag : mag;
      oscl_d  = scl_q;
      nan_d   = &scl_q;
      last_d  = cnt_end;
    end
  end

endmodule

// File: tb/tb_mx_blk_dec.sv
// tb_mx_blk_dec: directed and random streams for mx_blk_dec.
// Expected outputs come from an arithmetic decode model and a FIFO of pending results.
module tb_mx_blk_dec;

  localparam int W_O = 34;
  localparam int BS  = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     i_data;
  logic           i_valid;
  logic           o_ready;
  logic [W_O-1:0] o_num;
  logic [7:0]     o_scale;
  logic           o_nan;
  logic           o_last;
  logic           o_valid;
  logic           i_ready;

  mx_blk_dec dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_num   (o_num),
    .o_scale (o_scale),
    .o_nan   (o_nan),
    .o_last  (o_last),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W_O-1:0] num;
    logic [7:0]     scale;
    logic           nan;
    logic           last;
  } exp_t;

  exp_t       q[$];
  int         bidx;
  logic [7:0] mscale;
  int         n_pass;
  int         n_tot;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W_O-1:0] ref_num(input logic [7:0] d);
    longint mag;
    int     e;
    int     m;
    e = int'(d[6:2]);
    m = int'(d[1:0]);
    if (e == 0) mag = longint'(m);
    else mag = longint'(4 + m) * (longint'(1) << (e - 1));
    if (d[7]) mag = -mag;
    return mag[W_O-1:0];
  endfunction

  task automatic step(input logic v, input logic [7:0] d,
                      input logic r, output logic acc);
    logic rdy;
    exp_t x;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    #1;
    rdy = (q.size() == 0) || r;
    chk("o_ready", 64'(o_ready), 64'(rdy));
    chk("o_valid", 64'(o_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("o_num", 64'(o_num), 64'(q[0].num));
      chk("o_scale", 64'(o_scale), 64'(q[0].scale));
      chk("o_nan", 64'(o_nan), 64'(q[0].nan));
      chk("o_last", 64'(o_last), 64'(q[0].last));
      if (r) void'(q.pop_front());
    end
    acc = v && rdy;
    if (acc) begin
      if (bidx == 0) begin
        mscale = d;
        bidx   = 1;
      end else begin
        x.num   = ref_num(d);
        x.scale = mscale;
        x.nan   = (mscale == 8'hFF);
        x.last  = (bidx == BS);
        q.push_back(x);
        bidx = (bidx == BS) ? 0 : bidx + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until accepted, with optional random gaps/backpressure.
  task automatic send(input logic [7:0] d, input bit rnd);
    logic acc;
    logic v;
    logic r;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      step(v, v ? d : 8'($urandom), r, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    bidx = 0;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_num", 64'(o_num), 64'(0));
    chk("rst_scale", 64'(o_scale), 64'(0));
    chk("rst_nan", 64'(o_nan), 64'(0));
    chk("rst_last", 64'(o_last), 64'(0));
    chk("rst_ready", 64'(o_ready), 64'(1));
  endtask

  logic acc;
  logic [7:0] dir[6];

  initial begin
    n_pass  = 0;
    n_tot   = 0;
    bidx    = 0;
    mscale  = 8'h00;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed values, including negative and negative-zero elements.
    chk("ref_4", 64'(ref_num(8'h04)), 64'(4));
    chk("ref_7s30", 64'(ref_num(8'h7F)), 64'(34'(64'd7 << 30)));
    chk("ref_m10", 64'(ref_num(8'h89)), 64'(34'h3_FFFF_FFF6));
    dir = '{8'h04, 8'h01, 8'h0B, 8'h7F, 8'h89, 8'h80};
    send(8'h7F, 1'b0);
    for (int i = 0; i < 6; i++) send(dir[i], 1'b0);
    for (int i = 6; i < BS; i++) send(8'($urandom), 1'b0);

    // NaN block back to back with the previous last element.
    send(8'hFF, 1'b0);
    for (int i = 0; i < BS; i++) send(8'($urandom), 1'b0);

    // Backpressure: five stalled cycles with a new element pending.
    send(8'h22, 1'b0);
    send(8'h0B, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h89, 1'b0, acc);
    send(8'h89, 1'b0);
    for (int i = 2; i < BS; i++) send(8'($urandom), 1'b0);

    // Mid-block reset discards in-flight data.
    send(8'h33, 1'b0);
    for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0);
    do_reset();
    send(8'h10, 1'b0);
    for (int i = 0; i < BS; i++) send(8'($urandom), 1'b0);

    // All 256 codes with random gaps and random scales.
    for (int b = 0; b < 8; b++) begin
      send((b == 3) ? 8'hFF : 8'($urandom), 1'b1);
      for (int i = 0; i < BS; i++) send(8'(b * BS + i), 1'b1);
    end

    // Drain.
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, acc);
    chk("drained", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
